// File: rtl/data_mem_if.sv
// data_mem_if: load/store request and response handshake between core and data memory.
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [1:0]  req_dqm;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master (
    output req_valid, req_addr, req_write, req_dqm, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_addr, req_write, req_dqm, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency load/store responder around a word RAM with byte-lane writes.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic       clk,
  input logic       rst,
  data_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [31:0]     r_mem [DEPTH_WORDS];
  logic [31:0]     r_rdata;
  logic            r_err;
  logic            w_acc, w_oor, w_err;
  logic [AW-1:0]   w_idx;
  logic [1:0]      w_lane;
  logic [3:0]      w_be;
  logic [31:0]     w_wd, w_word, w_shift, w_load;
  assign w_idx   = bus.req_addr[AW+1:2];
  assign w_lane  = bus.req_addr[1:0];
  assign w_oor   = |(bus.req_addr >> (AW + 2));
  assign w_err   = bus.req_dqm == 2'b11 || (bus.req_dqm == 2'b01 && w_lane[0]) ||
                   (bus.req_dqm == 2'b10 && w_lane != 2'b00) || w_oor;
  assign w_acc   = r_state == IDLE && bus.req_valid && !rst;
  // Store data is replicated across lanes so the byte enables alone pick the destination.
  assign w_be    = bus.req_dqm == 2'b00 ? 4'b0001 << w_lane :
                   bus.req_dqm == 2'b01 ? 4'b0011 << w_lane : 4'b1111;
  assign w_wd    = bus.req_dqm == 2'b00 ? {4{bus.req_wdata[7:0]}} :
                   bus.req_dqm == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {w_lane, 3'b000};
  assign w_load  = bus.req_dqm == 2'b00 ? {24'b0, w_shift[7:0]} :
                   bus.req_dqm == 2'b01 ? {16'b0, w_shift[15:0]} : w_shift;
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    case (r_state)
      IDLE: if (bus.req_valid) begin
        w_next = LATENCY == 1 ? RESP : WAIT;
        w_cnt  = CW'(LATENCY - 1);
      end
      WAIT: begin
        w_next = r_cnt == CW'(1) ? RESP : WAIT;
        w_cnt  = r_cnt - CW'(1);
      end
      default: w_next = bus.rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (w_acc) begin
        r_rdata <= (bus.req_write || w_err) ? 32'h0 : w_load;
        r_err   <= w_err;
      end
    end
  end
  // Storage is deliberately outside reset so committed stores survive it.
  always_ff @(posedge clk) begin
    if (w_acc && bus.req_write && !w_err)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b+:8] <= w_wd[8*b+:8];
  end
  assign bus.req_ready = r_state == IDLE;
  assign bus.rsp_valid = r_state == RESP;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
endmodule
